dmem_port: RTL and testbench

- Byte-addressed synchronous data memory that sits directly downstream of the load/store formatting controller.
- Stores into byte lanes from `wdata` low bytes.
- Returns the addressed word shifted so the target byte or half lands in `rdata[7:0]` / `rdata[15:0]`, where the controller's sign/zero extension expects it.
- Adds a request/ready handshake with configurable wait states so the core can stall on memory.

---
 rtl/dmem_port.sv | 150 +++++++++++++++
 tb/tb_dmem_port.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dmem_port.sv
// dmem_port: byte-addressed synchronous data memory with a req/ready handshake and WAIT wait states.
// Define DMEM_MISALIGN_FAULT_EN to fault on misaligned accesses; otherwise they are force-aligned.
module dmem_port #(
    parameter int SIZE = 12,
    parameter int WAIT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic            we,
    input  logic [1:0]      size,
    input  logic [SIZE-1:0] addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            ready,
    output logic            fault
);
    localparam int         WORDS     = 2 ** (SIZE - 2);
    localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state;
    logic [3:0]      count;
    logic            we_q;
    logic [1:0]      size_q;
    logic [SIZE-1:0] addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     mem [WORDS];

    logic            cur_we;
    logic [1:0]      cur_size;
    logic [SIZE-1:0] cur_addr;
    logic [31:0]     cur_wdata;
    logic [SIZE-3:0] cur_word;
    logic [1:0]      raw_off;
    logic [1:0]      offset;
    logic            is_half;
    logic            is_word;
    logic            misaligned;
    logic            commit;
    logic [3:0]      lane_en;
    logic [31:0]     lane_data;

    // With WAIT=0 the accept edge is also the commit edge, so the live inputs drive the access.
    always_comb begin
        cur_we    = we_q;
        cur_size  = size_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state == IDLE) begin
            cur_we    = we;
            cur_size  = size;
            cur_addr  = addr;
            cur_wdata = wdata;
        end
    end

    assign cur_word = cur_addr[SIZE-1:2];
    assign raw_off  = cur_addr[1:0];
    assign is_half  = (cur_size == 2'b01);
    assign is_word  = cur_size[1];
    assign commit   = rst_n && (((state == IDLE) && req && (WAIT == 0)) ||
                                ((state == BUSY) && (count == 4'd0)));

`ifdef DMEM_MISALIGN_FAULT_EN
    assign misaligned = (is_half && raw_off[0]) || (is_word && (raw_off != 2'b00));
    assign offset     = raw_off;
`else
    assign misaligned = 1'b0;
    assign offset     = is_word ? 2'b00 : (is_half ? {raw_off[1], 1'b0} : raw_off);
`endif

    always_comb begin
        lane_en   = 4'b1111;
        lane_data = cur_wdata;
        if (!is_word) begin
            if (is_half) begin
                lane_en   = offset[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_wdata[15:0]}};
            end else begin
                lane_en   = 4'b0001 << offset;
                lane_data = {4{cur_wdata[7:0]}};
            end
        end
    end

    // The array has no reset: contents survive rst_n, only the in-flight access is dropped.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[cur_word][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= 4'd0;
            ready   <= 1'b0;
            fault   <= 1'b0;
            rdata   <= 32'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            ready <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (WAIT == 0) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                            count <= WAIT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (count == 4'd0) begin
                        state <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            // Loads return the word shifted so the addressed byte/half sits at bit 0.
            if (commit) begin
                ready <= 1'b1;
                fault <= misaligned;
                if (misaligned) begin
                    rdata <= 32'd0;
                end else if (!cur_we) begin
                    rdata <= mem[cur_word] >> {offset, 3'b000};
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_port.sv
// tb_dmem_port: directed checks of dmem_port with WAIT=0, WAIT=1 and WAIT=3 instances.
module tb_dmem_port;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [1:0]  size;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        req0, req1, req3;
    logic [31:0] rdata0, rdata1, rdata3;
    logic        ready0, ready1, ready3;
    logic        fault0, fault1, fault3;
    int          sel;
    logic [31:0] cur_rdata;
    logic        cur_ready;
    logic        cur_fault;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_port #(.SIZE(12), .WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata0), .ready(ready0), .fault(fault0));
    dmem_port #(.SIZE(12), .WAIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata1), .ready(ready1), .fault(fault1));
    dmem_port #(.SIZE(12), .WAIT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata3), .ready(ready3), .fault(fault3));

    assign cur_rdata = (sel == 0) ? rdata0 : (sel == 1) ? rdata1 : rdata3;
    assign cur_ready = (sel == 0) ? ready0 : (sel == 1) ? ready1 : ready3;
    assign cur_fault = (sel == 0) ? fault0 : (sel == 1) ? fault1 : fault3;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Holds req until ready; lat counts edges from the accept edge inclusive.
    task automatic applyStimulus(input int which, input logic w, input logic [1:0] sz,
                                 input logic [11:0] a, input logic [31:0] d,
                                 output logic [31:0] rd, output logic flt, output int lat);
        @(negedge clk);
        sel = which; we = w; size = sz; addr = a; wdata = d;
        req0 = (which == 0); req1 = (which == 1); req3 = (which == 3);
        lat = 0; rd = 32'd0; flt = 1'b0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (cur_ready) break;
        end
        if (!cur_ready) begin
            checkOutput("timeout", 32'd1, 32'd0);
            lat = -1;
        end else begin
            rd  = cur_rdata;
            flt = cur_fault;
        end
        req0 = 1'b0; req1 = 1'b0; req3 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_drop", {31'd0, cur_ready}, 32'd0);
        checkOutput("fault_drop", {31'd0, cur_fault}, 32'd0);
    endtask

    task automatic runAccess(input string tag, input int which, input logic w, input logic [1:0] sz,
                             input logic [11:0] a, input logic [31:0] d, input logic check_rd,
                             input logic [31:0] exp_rd, input logic exp_flt, input int exp_lat);
        logic [31:0] rd;
        logic        flt;
        int          lat;
        applyStimulus(which, w, sz, a, d, rd, flt, lat);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_fault"}, {31'd0, flt}, {31'd0, exp_flt});
        if (check_rd) checkOutput({tag, "_rdata"}, rd, exp_rd);
    endtask

    logic [11:0] stream_addr [6] = '{12'h030, 12'h038, 12'h034, 12'h038, 12'h030, 12'h038};
    logic        stream_rdy  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] stream_data [6] = '{32'hA0A0A0A0, 32'h0, 32'hB1B1B1B1, 32'h0, 32'hA0A0A0A0, 32'h0};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        sel = 1; rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; req3 = 1'b0;
        we = 1'b0; size = 2'b00; addr = 12'h000; wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("idle_ready", {31'd0, ready1}, 32'd0);
            checkOutput("idle_fault", {31'd0, fault1}, 32'd0);
            checkOutput("idle_rdata", rdata1, 32'd0);
        end

        runAccess("sw010", 1, 1'b1, 2'b10, 12'h010, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0, 2);
        runAccess("lw010", 1, 1'b0, 2'b10, 12'h010, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, 2);
        runAccess("sb012", 1, 1'b1, 2'b00, 12'h012, 32'h000000A5, 1'b0, 32'd0, 1'b0, 2);
        runAccess("lw010b", 1, 1'b0, 2'b10, 12'h010, 32'd0, 1'b1, 32'hDEA5BEEF, 1'b0, 2);
        runAccess("lb013", 1, 1'b0, 2'b00, 12'h013, 32'd0, 1'b1, 32'h000000DE, 1'b0, 2);
        runAccess("lh012", 1, 1'b0, 2'b01, 12'h012, 32'd0, 1'b1, 32'h0000DEA5, 1'b0, 2);
`ifdef DMEM_MISALIGN_FAULT_EN
        runAccess("sh011", 1, 1'b1, 2'b01, 12'h011, 32'h00001234, 1'b0, 32'd0, 1'b1, 2);
        runAccess("lw010c", 1, 1'b0, 2'b10, 12'h010, 32'd0, 1'b1, 32'hDEA5BEEF, 1'b0, 2);
        runAccess("lw011", 1, 1'b0, 2'b10, 12'h011, 32'd0, 1'b1, 32'h00000000, 1'b1, 2);
`else
        runAccess("sh011", 1, 1'b1, 2'b01, 12'h011, 32'h00001234, 1'b0, 32'd0, 1'b0, 2);
        runAccess("lw010c", 1, 1'b0, 2'b10, 12'h010, 32'd0, 1'b1, 32'hDEA51234, 1'b0, 2);
        runAccess("lw011", 1, 1'b0, 2'b10, 12'h011, 32'd0, 1'b1, 32'hDEA51234, 1'b0, 2);
`endif

        // Abort a WAIT=3 store before its commit edge.
        runAccess("sw020pre", 3, 1'b1, 2'b10, 12'h020, 32'h00000000, 1'b0, 32'd0, 1'b0, 4);
        @(negedge clk);
        sel = 3; we = 1'b1; size = 2'b10; addr = 12'h020; wdata = 32'h11111111; req3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; req3 = 1'b0;
        pulses = 0;
        @(posedge clk);
        #1;
        if (ready3) pulses++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ready3) pulses++;
        end
        checkOutput("abort_ready_pulses", 32'(pulses), 32'd0);
        runAccess("lw020", 3, 1'b0, 2'b10, 12'h020, 32'd0, 1'b1, 32'h00000000, 1'b0, 4);

        runAccess("sw030", 0, 1'b1, 2'b10, 12'h030, 32'hA0A0A0A0, 1'b0, 32'd0, 1'b0, 1);
        runAccess("sw034", 0, 1'b1, 2'b10, 12'h034, 32'hB1B1B1B1, 1'b0, 32'd0, 1'b0, 1);
        runAccess("sw038", 0, 1'b1, 2'b10, 12'h038, 32'hC2C2C2C2, 1'b0, 32'd0, 1'b0, 1);
        // Address 0x038 is only presented during RESP and must never be sampled.
        @(negedge clk);
        sel = 0; we = 1'b0; size = 2'b10; req0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            addr = stream_addr[i];
            @(posedge clk);
            #1;
            checkOutput($sformatf("stream_ready%0d", i), {31'd0, ready0}, {31'd0, stream_rdy[i]});
            if (stream_rdy[i]) checkOutput($sformatf("stream_rdata%0d", i), rdata0, stream_data[i]);
            @(negedge clk);
        end
        req0 = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
